// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder: MEM-stage data-memory responder with a fixed access latency.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  req_ready_o,
    output logic                  stall_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  write_q;
    logic                  unsigned_q;
    logic [1:0]            size_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0]         idx;
    logic [1:0]            lane;
    logic                  commit;
    logic                  err_d;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wword_d;
    logic [DATA_WIDTH-1:0] rword;
    logic [DATA_WIDTH-1:0] rshift;
    logic [DATA_WIDTH-1:0] load_d;
    logic                  unused_addr;

    assign idx         = addr_q[AW+1:2];
    assign lane        = addr_q[1:0];
    assign unused_addr = ^addr_q[DATA_WIDTH-1:AW+2];
    assign commit      = rst_n && (state_q == WAIT) && (cnt_q == 4'd0);
    assign rword       = mem_q[idx];
    assign rshift      = rword >> {lane, 3'b000};

    always_comb begin
        err_d   = 1'b0;
        be_d    = 4'b0000;
        wword_d = wdata_q;
        load_d  = '0;
        case (size_q)
            2'b00: begin
                be_d    = 4'b0001 << lane;
                wword_d = {4{wdata_q[7:0]}};
                load_d  = unsigned_q ? {{(DATA_WIDTH-8){1'b0}}, rshift[7:0]}
                                     : {{(DATA_WIDTH-8){rshift[7]}}, rshift[7:0]};
            end
            2'b01: begin
                err_d   = lane[0];
                be_d    = lane[1] ? 4'b1100 : 4'b0011;
                wword_d = {2{wdata_q[15:0]}};
                load_d  = unsigned_q ? {{(DATA_WIDTH-16){1'b0}}, rshift[15:0]}
                                     : {{(DATA_WIDTH-16){rshift[15]}}, rshift[15:0]};
            end
            2'b10: begin
                err_d  = (lane != 2'b00);
                be_d   = 4'b1111;
                load_d = rword;
            end
            default: begin
                err_d = 1'b1;
            end
        endcase
    end

    // Array is deliberately unreset; a reset during WAIT suppresses the commit.
    always_ff @(posedge clk) begin
        if (commit && write_q && !err_d) begin
            for (int b = 0; b < 4; b++) begin
                if (be_d[b]) begin
                    mem_q[idx][8*b +: 8] <= wword_d[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (req_valid_i) begin
                        write_q    <= req_write_i;
                        size_q     <= req_size_i;
                        unsigned_q <= req_unsigned_i;
                        addr_q     <= req_addr_i;
                        wdata_q    <= req_wdata_i;
                        cnt_q      <= 4'(LATENCY - 1);
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_d;
                        rsp_rdata_q <= (write_q || err_d) ? '0 : load_d;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = rst_n && (state_q == IDLE);
    assign stall_o     = rst_n && (((state_q == IDLE) && req_valid_i) || (state_q == WAIT));
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder: randomized self-checking bench with a byte-array model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [7:0]  mdl [BYTES];
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_WIDTH (32),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_write_i   (req_write),
        .req_size_i    (req_size),
        .req_unsigned_i(req_unsigned),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_ready_o   (req_ready),
        .stall_o       (stall),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a);
        int          base = int'(a[11:0]);
        int          nb   = nbytes(sz);
        logic [31:0] v    = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(mdl[base+i]) << (8*i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int base = int'(a[11:0]);
        for (int i = 0; i < nbytes(sz); i++) mdl[base+i] = 8'(wd >> (8*i));
    endtask

    // Called at a falling edge with the DUT idle; returns just after a falling edge.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic hold);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        int          stalls;
        exp_e = exp_err(sz, a);
        exp_d = (wr || exp_e) ? 32'd0 : model_load(sz, uns, a);
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        #1;
        chk("ready_idle", req_ready, 1);
        stalls = stall ? 1 : 0;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 20) begin
            if (!hold) begin
                req_valid = 1'($urandom); req_write = 1'($urandom); req_size = 2'($urandom);
                req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            end
            #1;
            chk("ready_busy", req_ready, 0);
            if (stall) stalls++;
            n++;
            @(negedge clk);
        end
        req_valid = hold;
        #1;
        chk("rsp_latency", n, LAT);
        chk("stall_cycles", stalls, LAT + 1);
        chk("stall_resp", stall, 0);
        chk("ready_resp", req_ready, 0);
        chk("rsp_rdata", rsp_rdata, exp_d);
        chk("rsp_err", rsp_err, exp_e);
        if (wr && !exp_e) model_store(sz, a, wd);
        @(negedge clk);
        #1;
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("ready_back", req_ready, 1);
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_ready", req_ready, 0);
            chk("rst_stall", stall, 0);
            chk("rst_valid", rsp_valid, 0);
            chk("rst_rdata", rsp_rdata, 0);
            chk("rst_err", rsp_err, 0);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF, 0);
        do_req(0, 2'd2, 0, 32'h100, 32'h0, 0);
        chk("sw_lw_model", model_load(2'd2, 0, 32'h100), 32'hDEAD_BEEF);

        do_req(1, 2'd2, 0, 32'h40, 32'h80FF_7F01, 0);
        do_req(0, 2'd0, 0, 32'h43, 32'h0, 0);
        do_req(0, 2'd0, 1, 32'h43, 32'h0, 0);
        do_req(0, 2'd1, 0, 32'h40, 32'h0, 0);
        do_req(0, 2'd1, 0, 32'h42, 32'h0, 0);
        do_req(0, 2'd1, 1, 32'h42, 32'h0, 0);

        do_req(1, 2'd2, 0, 32'h20, 32'h1122_3344, 0);
        do_req(1, 2'd0, 0, 32'h21, 32'h0000_00AA, 0);
        do_req(1, 2'd1, 0, 32'h22, 32'h0000_BBCC, 0);
        do_req(0, 2'd2, 0, 32'h20, 32'h0, 0);

        do_req(1, 2'd2, 0, 32'h100, 32'h55, 0);
        do_req(1, 2'd2, 0, 32'h102, 32'hFFFF_FFFF, 0);
        do_req(0, 2'd2, 0, 32'h100, 32'h0, 0);
        do_req(0, 2'd1, 0, 32'h101, 32'h0, 0);
        do_req(0, 2'd3, 0, 32'h100, 32'h0, 0);

        do_req(1, 2'd2, 0, 32'h1000, 32'h1234_5678, 0);
        do_req(0, 2'd2, 0, 32'h0000, 32'h0, 1);
        do_req(0, 2'd2, 0, 32'h0000, 32'h0, 1);

        // Abort a store in flight: reset spans both the WAIT edge and the would-be commit edge.
        do_req(1, 2'd2, 0, 32'h80, 32'h0, 0);
        req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h80; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("abort_valid", rsp_valid, 0);
            chk("abort_rdata", rsp_rdata, 0);
            chk("abort_err", rsp_err, 0);
            chk("abort_ready", req_ready, 0);
            chk("abort_stall", stall, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        do_req(0, 2'd2, 0, 32'h80, 32'h0, 0);

        for (int w = 0; w < 16; w++) do_req(1, 2'd2, 0, 32'h200 + 32'(4*w), $urandom, 0);
        for (int k = 0; k < 150; k++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'h200 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 15)) << 12),
                   $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
